// File: rtl/gshare_ckpt_predictor.sv
// Gshare branch predictor: speculative GHR with per-branch checkpoint restore,
// and a PHT initialised by a one-row-per-cycle sweep after reset or flush.
module gshare_ckpt_predictor #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned OFFSET   = 2,
    parameter int unsigned IDX_LEN  = 10,
    parameter int unsigned HLEN     = 8,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned INIT_CNT = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               flush_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic               pred_req_i,
    output logic               pred_taken_o,
    output logic [IDX_LEN-1:0] pred_index_o,
    output logic [HLEN-1:0]    pred_ghr_o,
    input  logic               res_valid_i,
    input  logic [IDX_LEN-1:0] res_index_i,
    input  logic               res_taken_i,
    input  logic               res_mispred_i,
    input  logic [HLEN-1:0]    res_ghr_i,
    output logic               ready_o,
    output logic [31:0]        mispred_cnt_o
);
    localparam int unsigned ROWS = 2 ** IDX_LEN;

    typedef enum logic {
        S_INIT,
        S_READY
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_LEN-1:0] init_ptr_q, init_ptr_d;
    logic [HLEN-1:0]    ghr_q, ghr_d;
    logic [31:0]        mispred_cnt_q, mispred_cnt_d;

    logic [CNT_W-1:0]   pht_q [ROWS];
    logic               pht_we;
    logic [IDX_LEN-1:0] pht_waddr;
    logic [CNT_W-1:0]   pht_wdata;
    logic [CNT_W-1:0]   res_cnt_old, res_cnt_new;

    logic               unused_bits;
    assign unused_bits = ^{pc_i[XLEN-1:IDX_LEN+OFFSET], pc_i[OFFSET-1:0], res_ghr_i[HLEN-1]};

    assign pred_index_o  = pc_i[IDX_LEN+OFFSET-1:OFFSET] ^ IDX_LEN'(ghr_q);
    assign pred_taken_o  = (state_q == S_READY) & pht_q[pred_index_o][CNT_W-1];
    assign pred_ghr_o    = ghr_q;
    assign ready_o       = (state_q == S_READY);
    assign mispred_cnt_o = mispred_cnt_q;

    always_comb begin
        res_cnt_old = pht_q[res_index_i];
        res_cnt_new = res_cnt_old;
        if (res_taken_i) begin
            if (res_cnt_old != '1) res_cnt_new = res_cnt_old + 1'b1;
        end else begin
            if (res_cnt_old != '0) res_cnt_new = res_cnt_old - 1'b1;
        end
    end

    // A single PHT write port is shared between the init sweep and resolution updates.
    always_comb begin
        state_d       = state_q;
        init_ptr_d    = init_ptr_q;
        ghr_d         = ghr_q;
        mispred_cnt_d = mispred_cnt_q;
        pht_we        = 1'b0;
        pht_waddr     = res_index_i;
        pht_wdata     = res_cnt_new;
        if (flush_i) begin
            state_d       = S_INIT;
            init_ptr_d    = '0;
            ghr_d         = '0;
            mispred_cnt_d = '0;
        end else if (state_q == S_INIT) begin
            pht_we     = 1'b1;
            pht_waddr  = init_ptr_q;
            pht_wdata  = CNT_W'(INIT_CNT);
            init_ptr_d = init_ptr_q + 1'b1;
            if (&init_ptr_q) state_d = S_READY;
        end else begin
            pht_we = res_valid_i;
            if (res_valid_i && res_mispred_i) begin
                ghr_d = {res_ghr_i[HLEN-2:0], res_taken_i};
                if (mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + 32'd1;
            end else if (pred_req_i) begin
                ghr_d = {ghr_q[HLEN-2:0], pred_taken_o};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_INIT;
            init_ptr_q    <= '0;
            ghr_q         <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            init_ptr_q    <= init_ptr_d;
            ghr_q         <= ghr_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // No reset on the table so it maps onto SRAM; the sweep provides initial contents.
    always_ff @(posedge clk_i) begin
        if (pht_we) pht_q[pht_waddr] <= pht_wdata;
    end
endmodule

// File: tb/tb_gshare_ckpt_predictor.sv
// Self-checking bench for gshare_ckpt_predictor: directed vector table,
// flush sequences and randomized traffic against a behavioural model.
module tb_gshare_ckpt_predictor;
    localparam int XLEN     = 32;
    localparam int OFFSET   = 2;
    localparam int IDX_LEN  = 4;
    localparam int HLEN     = 4;
    localparam int CNT_W    = 2;
    localparam int INIT_CNT = 1;
    localparam int ROWS     = 16;
    localparam int CMAX     = 3;

    logic               clk_i = 1'b0;
    logic               rst_n_i = 1'b0;
    logic               flush_i = 1'b0;
    logic [XLEN-1:0]    pc_i = '0;
    logic               pred_req_i = 1'b0;
    logic               pred_taken_o;
    logic [IDX_LEN-1:0] pred_index_o;
    logic [HLEN-1:0]    pred_ghr_o;
    logic               res_valid_i = 1'b0;
    logic [IDX_LEN-1:0] res_index_i = '0;
    logic               res_taken_i = 1'b0;
    logic               res_mispred_i = 1'b0;
    logic [HLEN-1:0]    res_ghr_i = '0;
    logic               ready_o;
    logic [31:0]        mispred_cnt_o;

    always #5 clk_i = ~clk_i;

    gshare_ckpt_predictor #(
        .XLEN(XLEN), .OFFSET(OFFSET), .IDX_LEN(IDX_LEN),
        .HLEN(HLEN), .CNT_W(CNT_W), .INIT_CNT(INIT_CNT)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .pc_i(pc_i),
        .pred_req_i(pred_req_i), .pred_taken_o(pred_taken_o),
        .pred_index_o(pred_index_o), .pred_ghr_o(pred_ghr_o),
        .res_valid_i(res_valid_i), .res_index_i(res_index_i),
        .res_taken_i(res_taken_i), .res_mispred_i(res_mispred_i),
        .res_ghr_i(res_ghr_i), .ready_o(ready_o), .mispred_cnt_o(mispred_cnt_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic        req;
        logic        rv;
        logic [3:0]  ridx;
        logic        rt;
        logic        rm;
        logic [3:0]  rghr;
        logic [3:0]  e_idx;
        logic        e_taken;
        logic [3:0]  e_ghr;
        logic [31:0] e_mc;
    } vec_t;

    vec_t vecs[20];

    int checks = 0;
    int errors = 0;

    // Behavioural model: counter values per row, history as an integer,
    // and the number of sweep edges since reset/flush.
    int          pht_m[ROWS];
    int          ghr_m;
    bit          ready_m;
    int          init_edges_m;
    longint      mc_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_idx();
        return int'((pc_i >> OFFSET) % ROWS) ^ ghr_m;
    endfunction

    function automatic bit m_taken();
        return ready_m && (pht_m[m_idx()] >= 2);
    endfunction

    task automatic model_reset();
        init_edges_m = 0;
        ready_m      = 1'b0;
        ghr_m        = 0;
        mc_m         = 0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic req, input logic rv,
                         input logic [3:0] ridx, input logic rt, input logic rm,
                         input logic [3:0] rghr, input logic fl);
        pc_i = pc; pred_req_i = req; res_valid_i = rv; res_index_i = ridx;
        res_taken_i = rt; res_mispred_i = rm; res_ghr_i = rghr; flush_i = fl;
    endtask

    task automatic check_model();
        chk("ready", 64'(ready_o), 64'(ready_m));
        chk("pred_index", 64'(pred_index_o), 64'(m_idx()));
        chk("pred_taken", 64'(pred_taken_o), 64'(m_taken()));
        chk("pred_ghr", 64'(pred_ghr_o), 64'(ghr_m));
        chk("mispred_cnt", 64'(mispred_cnt_o), 64'(mc_m));
    endtask

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic advance();
        int idx;
        bit tk;
        idx = m_idx();
        tk  = m_taken();
        if (flush_i) begin
            model_reset();
        end else if (!ready_m) begin
            init_edges_m++;
            if (init_edges_m == ROWS) begin
                ready_m = 1'b1;
                for (int i = 0; i < ROWS; i++) pht_m[i] = INIT_CNT;
            end
        end else begin
            if (res_valid_i) begin
                if (res_taken_i) pht_m[res_index_i] = (pht_m[res_index_i] < CMAX) ? pht_m[res_index_i] + 1 : CMAX;
                else             pht_m[res_index_i] = (pht_m[res_index_i] > 0) ? pht_m[res_index_i] - 1 : 0;
            end
            if (res_valid_i && res_mispred_i) begin
                ghr_m = ((int'(res_ghr_i) << 1) | int'(res_taken_i)) % ROWS;
                if (mc_m < 64'hFFFF_FFFF) mc_m++;
            end else if (pred_req_i) begin
                ghr_m = ((ghr_m << 1) | int'(tk)) % ROWS;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle_cycle(input logic [31:0] pc);
        drive(pc, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_model();
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h14, 0, 1, 5, 1, 0, 0, 5, 0, 0, 0};
        vecs[1]  = '{32'h14, 0, 1, 5, 1, 0, 0, 5, 1, 0, 0};
        vecs[2]  = '{32'h14, 0, 1, 5, 1, 0, 0, 5, 1, 0, 0};
        vecs[3]  = '{32'h14, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0};
        vecs[4]  = '{32'h14, 0, 1, 5, 0, 0, 0, 5, 1, 0, 0};
        vecs[5]  = '{32'h14, 0, 1, 5, 0, 0, 0, 5, 1, 0, 0};
        vecs[6]  = '{32'h14, 0, 1, 5, 0, 0, 0, 5, 0, 0, 0};
        vecs[7]  = '{32'h14, 0, 1, 5, 0, 0, 0, 5, 0, 0, 0};
        vecs[8]  = '{32'h14, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0};
        vecs[9]  = '{32'h14, 0, 1, 5, 1, 0, 0, 5, 0, 0, 0};
        vecs[10] = '{32'h14, 0, 1, 5, 1, 0, 0, 5, 0, 0, 0};
        vecs[11] = '{32'h14, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0};
        vecs[12] = '{32'h14, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0};
        vecs[13] = '{32'h00, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        vecs[14] = '{32'h00, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0};
        vecs[15] = '{32'h00, 1, 1, 9, 1, 1, 5, 2, 0, 2, 0};
        vecs[16] = '{32'h00, 0, 0, 0, 0, 0, 0, 11, 0, 11, 1};
        vecs[17] = '{32'h08, 0, 0, 0, 0, 0, 0, 9, 1, 11, 1};
        vecs[18] = '{32'h00, 0, 0, 0, 1, 1, 0, 11, 0, 11, 1};
        vecs[19] = '{32'h00, 0, 0, 0, 0, 0, 0, 11, 0, 11, 1};

        model_reset();
        drive(32'h14, 1, 1, 5, 1, 1, 4'hF, 0);
        #2;
        chk("rst_ready", 64'(ready_o), 0);
        chk("rst_taken", 64'(pred_taken_o), 0);
        chk("rst_ghr", 64'(pred_ghr_o), 0);
        chk("rst_mc", 64'(mispred_cnt_o), 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Sweep after reset; prediction and resolution traffic must be ignored.
        for (int i = 0; i < ROWS; i++) begin
            drive($urandom, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                  1'($urandom), 4'($urandom), 0);
            #1;
            chk("init_ready_low", 64'(ready_o), 0);
            chk("init_taken_low", 64'(pred_taken_o), 0);
            check_model();
            advance();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ready_after_16", 64'(ready_o), 1);
        for (int i = 0; i < ROWS; i++) begin
            drive(32'(i << OFFSET), 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk("post_init_nt", 64'(pred_taken_o), 0);
            check_model();
            advance();
        end

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].pc, vecs[i].req, vecs[i].rv, vecs[i].ridx, vecs[i].rt,
                  vecs[i].rm, vecs[i].rghr, 0);
            #1;
            chk($sformatf("vec%0d_idx", i), 64'(pred_index_o), 64'(vecs[i].e_idx));
            chk($sformatf("vec%0d_taken", i), 64'(pred_taken_o), 64'(vecs[i].e_taken));
            chk($sformatf("vec%0d_ghr", i), 64'(pred_ghr_o), 64'(vecs[i].e_ghr));
            chk($sformatf("vec%0d_mc", i), 64'(mispred_cnt_o), 64'(vecs[i].e_mc));
            check_model();
            advance();
        end

        // Flush in READY, then flush again mid-sweep at row 7.
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        check_model();
        advance();
        for (int i = 0; i < 7; i++) idle_cycle(32'h24);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("flush_mid_ready_low", 64'(ready_o), 0);
        check_model();
        advance();
        for (int i = 0; i < ROWS; i++) begin
            drive(32'h24, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk("reflush_ready_low", 64'(ready_o), 0);
            check_model();
            advance();
        end
        drive(32'h24, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reflush_ready", 64'(ready_o), 1);
        chk("flush_row9_nt", 64'(pred_taken_o), 0);
        chk("flush_ghr", 64'(pred_ghr_o), 0);
        chk("flush_mc", 64'(mispred_cnt_o), 0);
        pc_i = 32'h14;
        #1;
        chk("flush_row5_nt", 64'(pred_taken_o), 0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 500; i++) begin
            drive($urandom, 1'($urandom), ($urandom_range(0, 9) < 7), 4'($urandom),
                  1'($urandom), ($urandom_range(0, 9) < 3), 4'($urandom),
                  ($urandom_range(0, 99) == 0));
            #1;
            check_model();
            advance();
        end

        // Asynchronous reset in the middle of a low clock phase.
        #2;
        rst_n_i = 1'b0;
        #1;
        model_reset();
        chk("arst_ready", 64'(ready_o), 0);
        chk("arst_taken", 64'(pred_taken_o), 0);
        chk("arst_ghr", 64'(pred_ghr_o), 0);
        chk("arst_mc", 64'(mispred_cnt_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gshare_ckpt_predictor.md
Name: gshare_ckpt_predictor

Overview:
Second-generation global-history branch predictor for the fetch stage. The PHT depth, history length and counter width are set independently by parameters. The global history register (GHR) is updated speculatively at prediction time and restored from a per-branch checkpoint on a mispredict. After reset or flush, the PHT is re-initialised by a one-row-per-cycle sweep FSM, which keeps the table SRAM-mappable.

Parameters:
XLEN, 32, PC width
OFFSET, 2, PC LSBs dropped before indexing
IDX_LEN, 10, PHT index bits; PHT rows = 2**IDX_LEN
HLEN, 8, GHR bits; legal range 2 <= HLEN <= IDX_LEN
CNT_W, 2, saturating counter width; legal range >= 1
INIT_CNT, 1, counter value written by the init sweep; legal range < 2**CNT_W

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset
flush_i  in  1  synchronous flush: clear GHR, restart init sweep
pc_i  in  XLEN  fetch PC
pred_req_i  in  1  prediction consumed this cycle; advances the speculative GHR
pred_taken_o  out  1  predicted direction
pred_index_o  out  IDX_LEN  PHT index used for the prediction; carried down the pipe
pred_ghr_o  out  HLEN  GHR value before this prediction's update (checkpoint)
res_valid_i  in  1  branch resolution valid
res_index_i  in  IDX_LEN  pred_index_o of the resolving branch
res_taken_i  in  1  actual direction
res_mispred_i  in  1  direction was mispredicted
res_ghr_i  in  HLEN  pred_ghr_o checkpoint of the resolving branch
ready_o  out  1  predictor operational (FSM in READY)
mispred_cnt_o  out  32  saturating mispredict count

Behaviour:
- Reset and clock: rst_n_i is asynchronous, active-low; all state is clocked on clk_i.
- Index (combinational): pred_index_o = pc_i[IDX_LEN+OFFSET-1:OFFSET] XOR zero-extended ghr.
- Prediction outputs: pred_taken_o = PHT[pred_index_o][CNT_W-1] when ready_o=1, else 0. pred_ghr_o = ghr.
- FSM has two states:
  - INIT: init_ptr (IDX_LEN bits) writes INIT_CNT to PHT[init_ptr] on each edge, then increments. On the edge that writes row 2**IDX_LEN-1, the FSM moves to READY.
  - READY: normal operation.
- Async reset: state=INIT, init_ptr=0, ghr=0, mispred_cnt_o=0. Output values during reset: ready_o=0, pred_taken_o=0, pred_ghr_o=0. ready_o rises after exactly 2**IDX_LEN rising edges following reset release.
- flush_i (either state): next state=INIT, init_ptr=0, ghr=0, mispred_cnt=0. Flush during INIT restarts the sweep from row 0.
- During INIT: pred_req_i and res_valid_i are ignored (no GHR change, no counter change, no count).
- GHR speculation (READY, pred_req_i=1, no mispredict recovery this cycle): ghr <= {ghr[HLEN-2:0], pred_taken_o}. The newest outcome is at the LSB.
- Counter update (READY, res_valid_i=1): PHT[res_index_i] increments if taken, decrements otherwise. It saturates at 2**CNT_W-1 and at 0. The write is visible from the next cycle.
- Same-cycle read/write: there is no bypass. A prediction reading res_index_i in the update cycle sees the old value.
- Mispredict recovery (READY, res_valid_i & res_mispred_i): ghr <= {res_ghr_i[HLEN-2:0], res_taken_i}. This has priority over a same-cycle pred_req_i shift, whose shift is discarded. mispred_cnt_o increments and saturates at 2**32-1.
- res_mispred_i without res_valid_i is ignored.
- Priority order: reset > flush > INIT sweep > mispredict recovery > speculative shift.

Test Plan:
Bench parameters for all scenarios: IDX_LEN=4, HLEN=4, CNT_W=2, INIT_CNT=1.
1. Reset release -> ready_o=0 for 16 edges, then 1. pred_taken_o=0 throughout. Afterwards every index predicts not-taken (counter=1).
2. GHR=0, res_valid index 5 taken x3 -> counter 1,2,3,3. pc_i=0x14 -> pred_taken_o=1. Then 4x not-taken -> counter 2,1,0,0 and pred_taken_o=0.
3. ready_o=1, ghr=0, index 5 trained taken, pc_i=0x14, pred_req_i=1 -> pred_ghr_o=0000, next ghr=0001. Then a not-taken prediction -> ghr=0010.
4. pred_req_i=1 together with res_valid/res_mispred, res_ghr_i=0101, res_taken_i=1 -> ghr=1011 (shift discarded), mispred_cnt_o 0->1.
5. flush_i at init_ptr=7 during INIT -> sweep restarts at 0, ready_o after 16 more edges. Flush in READY -> trained counters return to 1, ghr=0, mispred_cnt_o=0.
6. Resolution to index 5 (counter 1, taken) while predicting index 5 in the same cycle -> pred_taken_o=0 this cycle, 1 the next cycle.
